// File: rtl/rasterizer_backend.sv
// rasterizer_backend: bounding-box walk with incremental edge functions.
// Define RASTERIZER_BACKEND_EMIT_ALL_EN to emit every box pixel.
module rasterizer_backend #(
  parameter int DATAWIDTH = 12,
  parameter int ACCWIDTH  = 24
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_dv,
  output logic                        ready,
  input  logic signed [DATAWIDTH-1:0] i_bb_tl [2],
  input  logic signed [DATAWIDTH-1:0] i_bb_br [2],
  input  logic signed [DATAWIDTH-1:0] i_edge_val0,
  input  logic signed [DATAWIDTH-1:0] i_edge_val1,
  input  logic signed [DATAWIDTH-1:0] i_edge_val2,
  input  logic signed [DATAWIDTH-1:0] i_edge_delta0 [2],
  input  logic signed [DATAWIDTH-1:0] i_edge_delta1 [2],
  input  logic signed [DATAWIDTH-1:0] i_edge_delta2 [2],
  input  logic signed [DATAWIDTH-1:0] i_area_inv,
  output logic signed [DATAWIDTH-1:0] o_frag_x,
  output logic signed [DATAWIDTH-1:0] o_frag_y,
  output logic signed [ACCWIDTH-1:0]  o_frag_w0,
  output logic signed [ACCWIDTH-1:0]  o_frag_w1,
  output logic signed [ACCWIDTH-1:0]  o_frag_w2,
  output logic signed [DATAWIDTH-1:0] o_frag_area_inv,
  output logic                        o_frag_inside,
  output logic                        o_frag_valid,
  input  logic                        i_frag_ready,
  output logic                        o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_SCAN
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic signed [DATAWIDTH-1:0] r_tlx;
  logic signed [DATAWIDTH-1:0] r_tly;
  logic signed [DATAWIDTH-1:0] r_brx;
  logic signed [DATAWIDTH-1:0] r_bry;
  logic signed [DATAWIDTH-1:0] r_ainv;
  logic signed [DATAWIDTH-1:0] r_x;
  logic signed [DATAWIDTH-1:0] r_y;
  logic signed [ACCWIDTH-1:0]  r_e   [3];
  logic signed [ACCWIDTH-1:0]  r_dx  [3];
  logic signed [ACCWIDTH-1:0]  r_dy  [3];
  logic signed [ACCWIDTH-1:0]  r_row [3];
  logic signed [ACCWIDTH-1:0]  r_cur [3];
  logic signed [ACCWIDTH-1:0]  w_init [3];

  logic signed [DATAWIDTH-1:0] r_ox;
  logic signed [DATAWIDTH-1:0] r_oy;
  logic signed [ACCWIDTH-1:0]  r_ow  [3];
  logic signed [DATAWIDTH-1:0] r_oainv;
  logic                        r_oin;
  logic                        r_valid;
  logic                        r_done;

  logic w_empty;
  logic w_inside;
  logic w_emit;
  logic w_adv;
  logic w_xlast;
  logic w_ylast;

  function automatic logic signed [ACCWIDTH-1:0] sx(
    input logic signed [DATAWIDTH-1:0] v
  );
    return {{(ACCWIDTH-DATAWIDTH){v[DATAWIDTH-1]}}, v};
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_init[k] = r_e[k] + sx(r_tlx) * r_dx[k]
                + sx(r_tly) * r_dy[k];
    end
  end

  assign w_empty  = (r_tlx > r_brx) || (r_tly > r_bry);
  assign w_inside = !r_cur[0][ACCWIDTH-1]
                 && !r_cur[1][ACCWIDTH-1]
                 && !r_cur[2][ACCWIDTH-1];
  assign w_adv    = !r_valid || i_frag_ready;
  assign w_xlast  = !(r_x < r_brx);
  assign w_ylast  = !(r_y < r_bry);

`ifdef RASTERIZER_BACKEND_EMIT_ALL_EN
  assign w_emit = 1'b1;
`else
  assign w_emit = w_inside;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready = rstn;
        if (i_dv) w_state_nxt = S_INIT;
      end
      S_INIT: begin
        w_state_nxt = w_empty ? S_IDLE : S_SCAN;
      end
      S_SCAN: begin
        if (w_adv && w_xlast && w_ylast)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tlx   <= '0;
      r_tly   <= '0;
      r_brx   <= '0;
      r_bry   <= '0;
      r_ainv  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
      r_oainv <= '0;
      r_oin   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_e[k]   <= '0;
        r_dx[k]  <= '0;
        r_dy[k]  <= '0;
        r_row[k] <= '0;
        r_cur[k] <= '0;
        r_ow[k]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      if (r_valid && i_frag_ready) r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (i_dv) begin
            r_tlx   <= i_bb_tl[0];
            r_tly   <= i_bb_tl[1];
            r_brx   <= i_bb_br[0];
            r_bry   <= i_bb_br[1];
            r_ainv  <= i_area_inv;
            r_e[0]  <= sx(i_edge_val0);
            r_e[1]  <= sx(i_edge_val1);
            r_e[2]  <= sx(i_edge_val2);
            r_dx[0] <= sx(i_edge_delta0[0]);
            r_dy[0] <= sx(i_edge_delta0[1]);
            r_dx[1] <= sx(i_edge_delta1[0]);
            r_dy[1] <= sx(i_edge_delta1[1]);
            r_dx[2] <= sx(i_edge_delta2[0]);
            r_dy[2] <= sx(i_edge_delta2[1]);
          end
        end
        S_INIT: begin
          r_x <= r_tlx;
          r_y <= r_tly;
          for (int k = 0; k < 3; k++) begin
            r_row[k] <= w_init[k];
            r_cur[k] <= w_init[k];
          end
          if (w_empty) r_done <= 1'b1;
        end
        S_SCAN: begin
          if (w_adv) begin
            if (w_emit) begin
              r_ox    <= r_x;
              r_oy    <= r_y;
              r_oainv <= r_ainv;
              r_oin   <= w_inside;
              r_valid <= 1'b1;
              for (int k = 0; k < 3; k++)
                r_ow[k] <= r_cur[k];
            end
            if (!w_xlast) begin
              r_x <= r_x + 1'b1;
              for (int k = 0; k < 3; k++)
                r_cur[k] <= r_cur[k] + r_dx[k];
            end else if (!w_ylast) begin
              // next row restarts from the left-column accumulator
              r_x <= r_tlx;
              r_y <= r_y + 1'b1;
              for (int k = 0; k < 3; k++) begin
                r_row[k] <= r_row[k] + r_dy[k];
                r_cur[k] <= r_row[k] + r_dy[k];
              end
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_frag_x        = r_ox;
  assign o_frag_y        = r_oy;
  assign o_frag_w0       = r_ow[0];
  assign o_frag_w1       = r_ow[1];
  assign o_frag_w2       = r_ow[2];
  assign o_frag_area_inv = r_oainv;
  assign o_frag_inside   = r_oin;
  assign o_frag_valid    = r_valid;
  assign o_done          = r_done;

endmodule

// File: tb/tb_rasterizer_backend.sv
// tb_rasterizer_backend: triangles checked against direct
// edge-function evaluation over the box in raster order.
`timescale 1ns/1ps
module tb_rasterizer_backend;
  localparam int DW = 12;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_dv = 1'b0;
  logic ready;
  logic signed [DW-1:0] bb_tl [2];
  logic signed [DW-1:0] bb_br [2];
  logic signed [DW-1:0] ev0, ev1, ev2;
  logic signed [DW-1:0] d0 [2];
  logic signed [DW-1:0] d1 [2];
  logic signed [DW-1:0] d2 [2];
  logic signed [DW-1:0] ainv;
  logic signed [DW-1:0] fx, fy, fai;
  logic signed [AW-1:0] fw0, fw1, fw2;
  logic fin, fvalid, done;
  logic i_frag_ready = 1'b1;

  rasterizer_backend #(.DATAWIDTH(DW), .ACCWIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .i_dv(i_dv), .ready(ready),
    .i_bb_tl(bb_tl), .i_bb_br(bb_br),
    .i_edge_val0(ev0), .i_edge_val1(ev1), .i_edge_val2(ev2),
    .i_edge_delta0(d0), .i_edge_delta1(d1), .i_edge_delta2(d2),
    .i_area_inv(ainv),
    .o_frag_x(fx), .o_frag_y(fy),
    .o_frag_w0(fw0), .o_frag_w1(fw1), .o_frag_w2(fw2),
    .o_frag_area_inv(fai), .o_frag_inside(fin),
    .o_frag_valid(fvalid), .i_frag_ready(i_frag_ready),
    .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] y;
    logic signed [AW-1:0] w0;
    logic signed [AW-1:0] w1;
    logic signed [AW-1:0] w2;
    logic signed [DW-1:0] ai;
    logic                 in;
  } frag_t;

  frag_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_frag = 0, n_in = 0, n_done = 0;
  int t_acc = 0, t_done = 0;
  int rdy_mode = 0;
  int g_tx, g_ty, g_bx, g_by, g_e0, g_e1, g_e2;
  int g_a0, g_a1, g_b0, g_b1, g_c0, g_c1, g_ai;

`ifdef RASTERIZER_BACKEND_EMIT_ALL_EN
  localparam bit EMIT_ALL = 1'b1;
`else
  localparam bit EMIT_ALL = 1'b0;
`endif

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Every visible fragment must equal the oldest expected one.
  always @(negedge clk) begin
    if (!rstn) begin
      i_frag_ready = 1'b1;
    end else begin
      i_frag_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (fvalid) begin
        if (q.size() == 0) begin
          chk("unexpected_frag", 1, 0);
        end else begin
          chk("frag_x", $signed(fx), $signed(q[0].x));
          chk("frag_y", $signed(fy), $signed(q[0].y));
          chk("frag_w0", $signed(fw0), $signed(q[0].w0));
          chk("frag_w1", $signed(fw1), $signed(q[0].w1));
          chk("frag_w2", $signed(fw2), $signed(q[0].w2));
          chk("frag_ainv", $signed(fai), $signed(q[0].ai));
          chk("frag_inside", fin, q[0].in);
          if (i_frag_ready) begin
            void'(q.pop_front());
            n_frag++;
            if (fin) n_in++;
          end
        end
      end
      if (done) begin
        n_done++;
        t_done = cyc;
      end
    end
  end

  task automatic set_tri(input int tx, ty, bx, by, e0, e1, e2,
                         input int a0, a1, b0, b1, c0, c1, ai);
    g_tx = tx; g_ty = ty; g_bx = bx; g_by = by;
    g_e0 = e0; g_e1 = e1; g_e2 = e2;
    g_a0 = a0; g_a1 = a1; g_b0 = b0; g_b1 = b1;
    g_c0 = c0; g_c1 = c1; g_ai = ai;
    bb_tl[0] = DW'(tx); bb_tl[1] = DW'(ty);
    bb_br[0] = DW'(bx); bb_br[1] = DW'(by);
    ev0 = DW'(e0); ev1 = DW'(e1); ev2 = DW'(e2);
    d0[0] = DW'(a0); d0[1] = DW'(a1);
    d1[0] = DW'(b0); d1[1] = DW'(b1);
    d2[0] = DW'(c0); d2[1] = DW'(c1);
    ainv = DW'(ai);
  endtask

  task automatic model_push();
    frag_t f;
    for (int y = g_ty; y <= g_by; y++) begin
      for (int x = g_tx; x <= g_bx; x++) begin
        f.x  = DW'(x);
        f.y  = DW'(y);
        f.w0 = AW'(g_e0 + x * g_a0 + y * g_a1);
        f.w1 = AW'(g_e1 + x * g_b0 + y * g_b1);
        f.w2 = AW'(g_e2 + x * g_c0 + y * g_c1);
        f.ai = DW'(g_ai);
        f.in = !f.w0[AW-1] && !f.w1[AW-1] && !f.w2[AW-1];
        if (EMIT_ALL || f.in) q.push_back(f);
      end
    end
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic send();
    int n = 0;
    i_dv = 1'b1;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk("accept_timeout", 0, 1);
      i_dv = 1'b0;
      return;
    end
    model_push();
    @(posedge clk);
    @(negedge clk);
    i_dv = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_done(input int nd);
    int n = 0;
    while (n_done < nd && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n_done < nd) chk("done_timeout", n_done, nd);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic right_tri(input int mode, input bit timed);
    int nf, ni, nd;
    rdy_mode = mode;
    nf = n_frag; ni = n_in; nd = n_done;
    set_tri(0, 0, 4, 4, 0, 16, 0, 4, 0, -4, -4, 0, 4, 333);
    send();
    chk("ready_init", ready, 0);
    wait_done(nd + 1);
    if (timed) chk("rt_latency", t_done - t_acc, 26);
    drain();
    chk("rt_nfrag", n_frag - nf, EMIT_ALL ? 25 : 15);
    chk("rt_ninside", n_in - ni, 15);
    chk("rt_ndone", n_done - nd, 1);
  endtask

  initial begin
    int nd, nf;
    set_tri(0, 0, 3, 3, 5, 5, 5, 1, 1, 1, 1, 1, 1, 77);
    i_dv = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_valid", fvalid, 0);
    chk("rst_done", done, 0);
    chk("rst_inside", fin, 0);
    chk("rst_x", fx, 0);
    chk("rst_w1", fw1, 0);
    chk("rst_ainv", fai, 0);
    i_dv = 1'b0;
    rstn = 1'b1;
    #1;
    chk("ready_post_rst", ready, 1);
    @(negedge clk);
    chk("ready_idle", ready, 1);

    right_tri(0, 1'b1);
    right_tri(1, 1'b0);

    rdy_mode = 0;
    nd = n_done; nf = n_frag;
    set_tri(5, 2, 4, 2, 10, 10, 10, 1, 1, 1, 1, 1, 1, -9);
    send();
    wait_done(nd + 1);
    chk("empty_latency", t_done - t_acc, 1);
    chk("empty_ready", ready, 1);
    chk("empty_nfrag", n_frag - nf, 0);

    // Back-to-back with a stalled slot at the handover.
    rdy_mode = 1;
    nd = n_done;
    set_tri(0, 0, 4, 4, 0, 16, 0, 4, 0, -4, -4, 0, 4, 5);
    send();
    set_tri(1, 1, 3, 2, 3, 3, 3, 1, -1, -1, 1, 0, 0, -100);
    send();
    wait_done(nd + 2);
    drain();

    // Reset in the middle of a scan drops everything pending.
    set_tri(0, 0, 5, 5, 20, 20, 20, 1, 1, 1, 1, 1, 1, 42);
    send();
    repeat (8) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    q.delete();
    chk("midrst_valid", fvalid, 0);
    chk("midrst_ready", ready, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_idle", ready, 1);
    chk("midrst_valid2", fvalid, 0);

    rdy_mode = 1;
    nd = n_done;
    for (int i = 0; i < 40; i++) begin
      int tx, ty, w, h;
      tx = $urandom_range(0, 12) - 4;
      ty = $urandom_range(0, 12) - 4;
      w = $urandom_range(0, 7);
      h = $urandom_range(0, 6);
      set_tri(tx, ty, tx + w - 1, ty + h - 1,
              $urandom_range(0, 120) - 60,
              $urandom_range(0, 120) - 60,
              $urandom_range(0, 120) - 60,
              $urandom_range(0, 20) - 10,
              $urandom_range(0, 20) - 10,
              $urandom_range(0, 20) - 10,
              $urandom_range(0, 20) - 10,
              $urandom_range(0, 20) - 10,
              $urandom_range(0, 20) - 10,
              $urandom_range(0, 4095) - 2048);
      send();
    end
    wait_done(nd + 40);
    drain();
    chk("rand_ndone", n_done - nd, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
